// File: rtl/mdu_pkg.sv
// mdu_defs: shared opcodes, FSM states and default latencies for the multiply/divide unit.
package mdu_defs;
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  function automatic logic is_mul(input logic [3:0] op);
    return op == OP_MULT || op == OP_MULTU;
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational product, quotient and remainder for the four arithmetic MDU ops.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_dz
);
  logic [63:0] w_sp, w_up;
  logic [31:0] w_sb, w_ub, w_sq, w_sr, w_uq, w_ur;
  logic        w_ovf;
  // Zero and the signed overflow case divide by 1 instead, keeping the divider defined;
  // dividing 0x80000000 by 1 already yields the required quotient and zero remainder.
  assign w_ovf = i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF;
  assign w_sb  = (i_b == 32'd0 || w_ovf) ? 32'd1 : i_b;
  assign w_ub  = (i_b == 32'd0) ? 32'd1 : i_b;
  assign w_sp  = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_up  = {32'd0, i_a} * {32'd0, i_b};
  assign w_sq  = $signed(i_a) / $signed(w_sb);
  assign w_sr  = $signed(i_a) % $signed(w_sb);
  assign w_uq  = i_a / w_ub;
  assign w_ur  = i_a % w_ub;
  assign o_dz  = i_b == 32'd0;
  always_comb begin
    o_hi = i_op == OP_MULT ? w_sp[63:32] : i_op == OP_MULTU ? w_up[63:32] : i_op == OP_DIV ? w_sr : w_ur;
    o_lo = i_op == OP_MULT ? w_sp[31:0]  : i_op == OP_MULTU ? w_up[31:0]  : i_op == OP_DIV ? w_sq : w_uq;
  end
endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning HI/LO, with mfhi/mflo/mthi/mtlo service.
module mdu
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdu_out
);
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_phi, r_plo, r_hi, r_lo, w_hi, w_lo;
  logic        r_pwr, w_dz, w_free, w_go_mul, w_go_div, w_done;
  mdu_arith u_arith (.i_op(mdu_op), .i_a(A1), .i_b(A2), .o_hi(w_hi), .o_lo(w_lo), .o_dz(w_dz));
  assign busy     = r_state != S_IDLE;
  assign HI       = r_hi;
  assign LO       = r_lo;
  assign w_free   = start && !busy;
  assign w_go_mul = w_free && is_mul(mdu_op);
  assign w_go_div = w_free && is_div(mdu_op);
  assign w_done   = busy && r_cnt == 4'd1;
  always_comb begin
    w_next  = r_state;
    w_next  = r_state == S_IDLE ? (w_go_mul ? S_MUL : w_go_div ? S_DIV : S_IDLE) : (w_done ? S_IDLE : r_state);
    mdu_out = mdu_op == OP_MFHI ? r_hi : mdu_op == OP_MFLO ? r_lo : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
      r_pwr   <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_go_mul || w_go_div) begin
        r_cnt <= w_go_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        r_phi <= w_hi;
        r_plo <= w_lo;
        r_pwr <= w_go_mul || !w_dz;
      end else if (busy) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done && r_pwr) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
      if (w_free && mdu_op == OP_MTHI) r_hi <= A1;
      if (w_free && mdu_op == OP_MTLO) r_lo <= A1;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu; a reference model queues expected HI/LO and busy lengths.
module tb_mdu;
  import mdu_defs::*;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int cyc;} exp_t;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, busy;
  logic [3:0]  mdu_op = OP_NONE;
  logic [31:0] A1 = '0, A2 = '0, HI, LO, mdu_out;
  logic [31:0] m_hi = '0, m_lo = '0;
  exp_t        q[$];
  int          n_cmp = 0, n_bad = 0;

  mdu dut (.clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .A1(A1), .A2(A2),
           .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint p;
    longint unsigned u;
    e.hi = m_hi; e.lo = m_lo; e.cyc = is_mul(op) ? 5 : 10;
    if (op == OP_MULT) begin
      p = longint'($signed(a)) * longint'($signed(b));
      e.hi = p[63:32]; e.lo = p[31:0];
    end else if (op == OP_MULTU) begin
      u = longint'(a) * longint'(b);
      e.hi = u[63:32]; e.lo = u[31:0];
    end else if (op == OP_DIV && b != 0) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000; e.hi = 32'd0;
      end else begin
        e.lo = 32'(int'(a) / int'(b)); e.hi = 32'(int'(a) % int'(b));
      end
    end else if (op == OP_DIVU && b != 0) begin
      e.lo = a / b; e.hi = a % b;
    end
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    start = 1'b1; mdu_op = op; A1 = a; A2 = b;
    if (is_mul(op) || is_div(op)) begin
      e = model(op, a, b);
      q.push_back(e);
      m_hi = e.hi; m_lo = e.lo;
    end else if (op == OP_MTHI) m_hi = a;
    else if (op == OP_MTLO) m_lo = a;
    @(negedge clk);
    start = 1'b0; mdu_op = OP_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (HI !== 32'd0) begin n_bad++; $display("FAIL reset_hi got %h want 0", HI); end
    n_cmp++; if (LO !== 32'd0) begin n_bad++; $display("FAIL reset_lo got %h want 0", LO); end
    n_cmp++; if (mdu_out !== 32'd0) begin n_bad++; $display("FAIL reset_out got %h want 0", mdu_out); end
  endtask

  task automatic test_arith(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n;
    issue(op, a, b);
    wait_idle(n);
    e = q.pop_front();
    n_cmp++; if (n !== e.cyc) begin n_bad++; $display("FAIL %s_cycles got %0d want %0d", nm, n, e.cyc); end
    n_cmp++; if (HI !== e.hi) begin n_bad++; $display("FAIL %s_hi got %h want %h", nm, HI, e.hi); end
    n_cmp++; if (LO !== e.lo) begin n_bad++; $display("FAIL %s_lo got %h want %h", nm, LO, e.lo); end
  endtask

  task automatic test_plan_values;
    test_arith("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2);
    n_cmp++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL mult_const got %h_%h want ffffffff_fffffffe", HI, LO); end
    test_arith("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    n_cmp++; if ({HI, LO} !== 64'h0000_0001_FFFF_FFFE) begin n_bad++; $display("FAIL multu_const got %h_%h want 00000001_fffffffe", HI, LO); end
    test_arith("div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    n_cmp++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_bad++; $display("FAIL div_const got %h_%h want ffffffff_fffffffd", HI, LO); end
    test_arith("divu", OP_DIVU, 32'd7, 32'd2);
    n_cmp++; if ({HI, LO} !== 64'h0000_0001_0000_0003) begin n_bad++; $display("FAIL divu_const got %h_%h want 00000001_00000003", HI, LO); end
    test_arith("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    n_cmp++; if ({HI, LO} !== 64'h0000_0000_8000_0000) begin n_bad++; $display("FAIL div_ovf_const got %h_%h want 00000000_80000000", HI, LO); end
    test_arith("divu_big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_mthi_divzero;
    logic [31:0] lo_before;
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got %0b want 0", busy); end
    n_cmp++; if (HI !== 32'h1234_5678) begin n_bad++; $display("FAIL mthi_hi got %h want 12345678", HI); end
    lo_before = LO;
    test_arith("divu_zero", OP_DIVU, 32'd99, 32'd0);
    n_cmp++; if (HI !== 32'h1234_5678 || LO !== lo_before) begin n_bad++; $display("FAIL divzero_keep got %h_%h want 12345678_%h", HI, LO, lo_before); end
    mdu_op = OP_MFHI;
    #1;
    n_cmp++; if (mdu_out !== 32'h1234_5678) begin n_bad++; $display("FAIL mfhi got %h want 12345678", mdu_out); end
    issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    mdu_op = OP_MFLO;
    #1;
    n_cmp++; if (mdu_out !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mflo got %h want cafef00d", mdu_out); end
    mdu_op = OP_NONE;
    test_arith("div_zero", OP_DIV, 32'hFFFF_0000, 32'd0);
  endtask

  task automatic test_ignore_busy;
    exp_t e;
    int n;
    issue(OP_MULT, 32'h0001_0003, 32'hFFFF_FFF0);
    @(negedge clk);
    start = 1'b1; mdu_op = OP_MTLO; A1 = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0; mdu_op = OP_NONE;
    wait_idle(n);
    e = q.pop_front();
    n_cmp++; if (n + 2 !== e.cyc) begin n_bad++; $display("FAIL ignore_cycles got %0d want %0d", n + 2, e.cyc); end
    n_cmp++; if (LO !== e.lo || HI !== e.hi) begin n_bad++; $display("FAIL ignore_result got %h_%h want %h_%h", HI, LO, e.hi, e.lo); end
    @(negedge clk);
    start = 1'b1; mdu_op = 4'hF; A1 = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; mdu_op = OP_NONE;
    n_cmp++; if (busy !== 1'b0 || HI !== e.hi || LO !== e.lo) begin n_bad++; $display("FAIL undef_op got %0b %h_%h want 0 %h_%h", busy, HI, LO, e.hi, e.lo); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops [4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    for (int i = 0; i < 8; i++)
      test_arith("rand", ops[$urandom_range(0, 3)], $urandom, (i == 5) ? 32'd0 : $urandom_range(1, 32'hFFFF_FFFF));
  endtask

  task automatic test_reset_mid;
    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_hi = '0; m_lo = '0;
    n_cmp++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin n_bad++; $display("FAIL rst_mid got %0b %h_%h want 0 0_0", busy, HI, LO); end
    repeat (12) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin n_bad++; $display("FAIL rst_late got %0b %h_%h want 0 0_0", busy, HI, LO); end
    test_arith("after_rst", OP_MULTU, 32'd123456, 32'd654321);
  endtask

  initial begin
    test_reset();
    test_plan_values();
    test_mthi_divzero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
Multiply/divide unit for the EX stage of the pipelined CPU. It sits beside the ALU and consumes the same forwarded operands from the ID/EX register. It executes mult/multu/div/divu over multiple cycles and owns the HI/LO registers. It also serves mfhi/mflo/mthi/mtlo. Its busy flag feeds the hazard unit, which stalls any MDU instruction that arrives while an operation is in flight.

Parameters:
MULT_CYCLES, 5, cycles busy stays high after a mult/multu start (range 1-15)
DIV_CYCLES, 10, cycles busy stays high after a div/divu start (range 1-15)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  valid MDU instruction in EX this cycle; the hazard unit drives it 0 when EX is stalled or flushed
mdu_op  input  4  operation code (encodings in package)
A1  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
A2  input  32  operand rt (divisor / multiplier)
busy  output  1  multi-cycle operation in progress
HI  output  32  architectural HI register
LO  output  32  architectural LO register
mdu_out  output  32  combinational: HI when mdu_op=MFHI, LO when mdu_op=MFLO, else 0

Behaviour:
- Reset (synchronous, highest priority): HI=0, LO=0, busy=0, counter=0, state=IDLE, pending result=0. Reset mid-operation aborts it, and no result is ever written.
- FSM states:
  - IDLE to MUL on start & !busy & op in {MULT,MULTU}.
  - IDLE to DIV on start & !busy & op in {DIV,DIVU}.
  - MUL or DIV back to IDLE when the counter reaches 1.
- Start edge:
  - Compute the result from A1/A2 into pending hi/lo registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- Each busy cycle the counter decrements. On the edge where counter==1, pending is written to HI/LO and busy drops. Busy is therefore high for exactly N cycles, and HI/LO show the new value in the first cycle with busy=0.
- MULT: {HI,LO} = signed 32x32 product, 64 bits. MULTU: unsigned product.
- DIV: LO = quotient truncated toward zero, HI = remainder with the dividend's sign. DIVU: unsigned.
- 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divisor 0: busy runs the full DIV_CYCLES, and HI/LO keep their prior values (no write).
- MTHI/MTLO with start & !busy: HI (or LO) = A1 at the edge, with zero latency and busy staying 0.
- MFHI/MFLO: the read path is combinational and has no state effect. mdu_out reflects HI/LO as of the current cycle; there is no bypass of a same-cycle mthi.
- start asserted while busy: ignored entirely, with no state change. The hazard unit guarantees this never happens for valid instructions.
- start with op NONE or an undefined code: no effect.
- HI/LO are never modified except at completion, by mthi/mtlo, or by reset.

Decomposition:
- Shared package mdu_defs:
  - Op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - FSM state constants: IDLE, MUL, DIV.
  - Default latencies.
- One combinational sub-module, mdu_arith, computes signed/unsigned product, quotient and remainder from A1/A2/op.
- The top-level mdu holds the FSM, counter, pending registers and HI/LO.

Test Plan:
- MULT A1=0xFFFFFFFF, A2=0x00000002 -> busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV A1=0xFFFFFFF9 (-7), A2=2 -> busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- MTHI 0x12345678, then DIVU A2=0 -> after 10 cycles HI=0x12345678 and LO unchanged. MFHI then gives mdu_out=0x12345678.
- MULT started, then at cycle 2 start=1 with MTLO A1=0xAAAA5555 -> ignored; LO equals the product LO after completion.
- DIV started, reset=1 at busy cycle 4 -> next cycle busy=0, HI=LO=0, and no later write occurs.
